// File: rtl/elevator_pkg.sv
// Shared types and default geometry for the level elevator sequencer.
package elevator_pkg;

  localparam int ELEV_Y_W = 10;

  typedef enum logic [1:0] {
    AT_START,
    TO_END,
    AT_END,
    TO_START
  } elev_state_t;

  // Element [i] belongs to elevator/switch i.
  localparam logic [1:0][ELEV_Y_W-1:0] DEF_START_Y    = {10'd208, 10'd256};
  localparam logic [1:0][ELEV_Y_W-1:0] DEF_END_Y      = {10'd119, 10'd303};
  localparam logic [3:0][7:0]          DEF_SWITCH_MAP = {8'd1, 8'd1, 8'd0, 8'd0};

endpackage

// File: rtl/elevator_sequencer_if.sv
// Switch/frame inputs and per-elevator position/status outputs of the sequencer.
interface elevator_sequencer_if
  import elevator_pkg::*;
#(
  parameter int ELEV_COUNT   = 2,
  parameter int SWITCH_COUNT = 4
);
  logic                                 frame_clk;
  logic                                 freeze;
  logic [SWITCH_COUNT-1:0]              switch_pressed;
  logic [ELEV_COUNT-1:0][ELEV_Y_W-1:0]  elev_y;
  logic [ELEV_COUNT-1:0]                elev_on;
  logic [ELEV_COUNT-1:0]                elev_moving;
  logic [ELEV_COUNT-1:0]                elev_at_end;
  logic                                 move_tick;

  modport master (
    output frame_clk, freeze, switch_pressed,
    input  elev_y, elev_on, elev_moving, elev_at_end, move_tick
  );

  modport slave (
    input  frame_clk, freeze, switch_pressed,
    output elev_y, elev_on, elev_moving, elev_at_end, move_tick
  );
endinterface

// File: rtl/elevator_track.sv
// One elevator: travel FSM, position register and clamped step toward the active rest Y.
module elevator_track
  import elevator_pkg::*;
#(
  parameter logic [ELEV_Y_W-1:0] START_Y = 10'd256,
  parameter logic [ELEV_Y_W-1:0] END_Y   = 10'd303,
  parameter int                  STEP    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                step_en,
  input  logic                on,
  output logic [ELEV_Y_W-1:0] y,
  output logic                moving,
  output logic                at_end,
  output logic                moved
);

  localparam logic signed [ELEV_Y_W:0] START_S = signed'({1'b0, START_Y});
  localparam logic signed [ELEV_Y_W:0] END_S   = signed'({1'b0, END_Y});
  localparam logic signed [ELEV_Y_W:0] STEP_S  = (ELEV_Y_W+1)'(STEP);

  // Never overshoots: a remaining distance within one step lands exactly on target.
  function automatic logic signed [ELEV_Y_W:0] step_toward(
    input logic signed [ELEV_Y_W:0] cur,
    input logic signed [ELEV_Y_W:0] tgt
  );
    logic signed [ELEV_Y_W:0] diff;
    diff = tgt - cur;
    if (diff <= STEP_S && diff >= -STEP_S) return tgt;
    else if (diff > 0)                     return cur + STEP_S;
    else                                   return cur - STEP_S;
  endfunction

  elev_state_t              state;
  elev_state_t              next_state;
  logic signed [ELEV_Y_W:0] y_s;
  logic signed [ELEV_Y_W:0] tgt_s;
  logic signed [ELEV_Y_W:0] ny_s;
  logic                     go;
  logic                     arrived;

  always_comb begin
    y_s   = signed'({1'b0, y});
    tgt_s = on ? END_S : START_S;
    ny_s  = step_toward(y_s, tgt_s);
    arrived = (ny_s == tgt_s);
    case (state)
      AT_START:         go = on;
      AT_END:           go = !on;
      TO_END, TO_START: go = 1'b1;
      default:          go = 1'b0;
    endcase
    if (arrived) next_state = on ? AT_END : AT_START;
    else         next_state = on ? TO_END : TO_START;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= AT_START;
      y      <= START_Y;
      moving <= 1'b0;
      at_end <= 1'b0;
      moved  <= 1'b0;
    end else if (step_en && go) begin
      state  <= next_state;
      y      <= ny_s[ELEV_Y_W-1:0];
      moving <= !arrived;
      at_end <= arrived && on;
      moved  <= (ny_s != y_s);
    end else begin
      moved  <= 1'b0;
    end
  end

endmodule

// File: rtl/elevator_sequencer.sv
// Central elevator motion controller: frame-edge divider, switch demand and one track per elevator.
module elevator_sequencer
  import elevator_pkg::*;
#(
  parameter int                                  ELEV_COUNT   = 2,
  parameter int                                  SWITCH_COUNT = 4,
  parameter int                                  FRAME_DIV    = 4,
  parameter int                                  STEP         = 1,
  parameter logic [ELEV_COUNT-1:0][ELEV_Y_W-1:0] START_Y      = DEF_START_Y,
  parameter logic [ELEV_COUNT-1:0][ELEV_Y_W-1:0] END_Y        = DEF_END_Y,
  parameter logic [SWITCH_COUNT-1:0][7:0]        SWITCH_MAP   = DEF_SWITCH_MAP,
  parameter logic [SWITCH_COUNT-1:0]             LEVER_MASK   = 4'b0100
) (
  input  logic                 Clk,
  input  logic                 Reset,
  elevator_sequencer_if.slave  bus
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic                                frame_clk_d;
  logic                                frame_edge;
  logic [DIV_W-1:0]                    div;
  logic                                step_en;
  logic [SWITCH_COUNT-1:0]             sw_d;
  logic [SWITCH_COUNT-1:0]             lever;
  logic [ELEV_COUNT-1:0]               demand;
  logic [ELEV_COUNT-1:0]               elev_on;
  logic [ELEV_COUNT-1:0]               moved;
  logic [ELEV_COUNT-1:0]               moving;
  logic [ELEV_COUNT-1:0]               at_end;
  logic [ELEV_COUNT-1:0][ELEV_Y_W-1:0] y_arr;
  logic                                move_tick;

  assign step_en = frame_edge && !bus.freeze && (div == DIV_W'(FRAME_DIV - 1));

  always_comb begin
    demand = '0;
    for (int e = 0; e < ELEV_COUNT; e++) begin
      for (int i = 0; i < SWITCH_COUNT; i++) begin
        if (SWITCH_MAP[i] == 8'(e))
          demand[e] = demand[e] | (LEVER_MASK[i] ? lever[i] : bus.switch_pressed[i]);
      end
    end
  end

  // History resets high so a frame_clk already high at reset release is not an edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_d <= 1'b1;
      frame_edge  <= 1'b0;
      div         <= '0;
      sw_d        <= '0;
      lever       <= '0;
      elev_on     <= '0;
      move_tick   <= 1'b0;
    end else begin
      frame_clk_d <= bus.frame_clk;
      frame_edge  <= bus.frame_clk & ~frame_clk_d;
      if (frame_edge && !bus.freeze)
        div <= step_en ? '0 : div + 1'b1;
      sw_d        <= bus.switch_pressed;
      lever       <= lever ^ (bus.switch_pressed & ~sw_d & LEVER_MASK);
      elev_on     <= demand;
      move_tick   <= |moved;
    end
  end

  for (genvar e = 0; e < ELEV_COUNT; e++) begin : g_track
    elevator_track #(
      .START_Y (START_Y[e]),
      .END_Y   (END_Y[e]),
      .STEP    (STEP)
    ) u_track (
      .Clk     (Clk),
      .Reset   (Reset),
      .step_en (step_en),
      .on      (elev_on[e]),
      .y       (y_arr[e]),
      .moving  (moving[e]),
      .at_end  (at_end[e]),
      .moved   (moved[e])
    );
  end

  assign bus.elev_y      = y_arr;
  assign bus.elev_on     = elev_on;
  assign bus.elev_moving = moving;
  assign bus.elev_at_end = at_end;
  assign bus.move_tick   = move_tick;

endmodule

// File: tb/tb_elevator_sequencer.sv
// Directed bench: table of switch/edge vectors plus lever, freeze and STEP=5 clamp/reset sequences.
module tb_elevator_sequencer;
  import elevator_pkg::*;

  logic Clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 Clk = ~Clk;

  elevator_sequencer_if #(.ELEV_COUNT(2), .SWITCH_COUNT(4)) bus_a ();
  elevator_sequencer_if #(.ELEV_COUNT(2), .SWITCH_COUNT(4)) bus_b ();

  elevator_sequencer #(.FRAME_DIV(4), .STEP(1)) dut_a (.Clk(Clk), .Reset(rst_a), .bus(bus_a));
  elevator_sequencer #(.FRAME_DIV(1), .STEP(5)) dut_b (.Clk(Clk), .Reset(rst_b), .bus(bus_b));

  int n_cmp = 0;
  int n_bad = 0;
  int ticks_a = 0;

  always @(posedge Clk) if (bus_a.move_tick === 1'b1) ticks_a <= ticks_a + 1;

  typedef struct {
    logic [3:0] sw;
    int         edges;
    int         y0;
    int         y1;
    logic [1:0] on;
    logic [1:0] mov;
    logic [1:0] at_end;
    int         ticks;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic edges(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (sel_b) bus_b.frame_clk = 1'b1; else bus_a.frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      if (sel_b) bus_b.frame_clk = 1'b0; else bus_a.frame_clk = 1'b0;
      @(negedge Clk);
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic pulse_lever_a();
    @(negedge Clk);
    bus_a.switch_pressed = 4'b0100;
    @(negedge Clk);
    bus_a.switch_pressed = 4'b0000;
    repeat (3) @(negedge Clk);
  endtask

  initial begin
    int t0;
    vecs[0] = '{4'b0001,   3, 256, 208, 2'b01, 2'b00, 2'b00,  0};
    vecs[1] = '{4'b0001,   1, 257, 208, 2'b01, 2'b01, 2'b00,  1};
    vecs[2] = '{4'b0001,  92, 280, 208, 2'b01, 2'b01, 2'b00, 23};
    vecs[3] = '{4'b0000,   4, 279, 208, 2'b00, 2'b01, 2'b00,  1};
    vecs[4] = '{4'b0000,  92, 256, 208, 2'b00, 2'b00, 2'b00, 23};
    vecs[5] = '{4'b0001, 188, 303, 208, 2'b01, 2'b00, 2'b01, 47};
    vecs[6] = '{4'b0001,  20, 303, 208, 2'b01, 2'b00, 2'b01,  0};
    vecs[7] = '{4'b0000, 188, 256, 208, 2'b00, 2'b00, 2'b00, 47};

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.frame_clk = 1'b1; bus_a.freeze = 1'b0; bus_a.switch_pressed = '0;
    bus_b.frame_clk = 1'b1; bus_b.freeze = 1'b0; bus_b.switch_pressed = '0;
    repeat (4) @(negedge Clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge Clk);

    check("reset_y0", 32'(bus_a.elev_y[0]), 256);
    check("reset_y1", 32'(bus_a.elev_y[1]), 208);
    check("reset_on", 32'(bus_a.elev_on), 0);
    check("reset_moving", 32'(bus_a.elev_moving), 0);
    check("reset_at_end", 32'(bus_a.elev_at_end), 0);
    check("reset_move_tick", 32'(bus_a.move_tick), 0);
    bus_a.frame_clk = 1'b0;
    bus_b.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);

    for (int v = 0; v < 8; v++) begin
      t0 = ticks_a;
      @(negedge Clk);
      bus_a.switch_pressed = vecs[v].sw;
      edges(1'b0, vecs[v].edges);
      check($sformatf("vec%0d_y0", v), 32'(bus_a.elev_y[0]), 32'(vecs[v].y0));
      check($sformatf("vec%0d_y1", v), 32'(bus_a.elev_y[1]), 32'(vecs[v].y1));
      check($sformatf("vec%0d_on", v), 32'(bus_a.elev_on), 32'(vecs[v].on));
      check($sformatf("vec%0d_moving", v), 32'(bus_a.elev_moving), 32'(vecs[v].mov));
      check($sformatf("vec%0d_at_end", v), 32'(bus_a.elev_at_end), 32'(vecs[v].at_end));
      check($sformatf("vec%0d_ticks", v), 32'(ticks_a - t0), 32'(vecs[v].ticks));
    end

    // Lever on elevator 1: toggle, reverse mid-travel, long hold toggles once.
    pulse_lever_a();
    edges(1'b0, 4);
    check("lever_first_step_y1", 32'(bus_a.elev_y[1]), 207);
    check("lever_on", 32'(bus_a.elev_on), 32'(2'b10));
    check("lever_moving", 32'(bus_a.elev_moving), 32'(2'b10));
    edges(1'b0, 40);
    check("lever_travel_y1", 32'(bus_a.elev_y[1]), 197);
    pulse_lever_a();
    edges(1'b0, 4);
    check("lever_reverse_y1", 32'(bus_a.elev_y[1]), 198);
    check("lever_reverse_on", 32'(bus_a.elev_on), 0);
    @(negedge Clk);
    bus_a.switch_pressed = 4'b0100;
    repeat (500) @(negedge Clk);
    bus_a.switch_pressed = 4'b0000;
    repeat (3) @(negedge Clk);
    check("lever_hold_once_on", 32'(bus_a.elev_on), 32'(2'b10));
    edges(1'b0, 4);
    check("lever_hold_y1", 32'(bus_a.elev_y[1]), 197);

    // Freeze holds divider and position while lever toggles are still captured.
    edges(1'b0, 2);
    t0 = ticks_a;
    bus_a.freeze = 1'b1;
    edges(1'b0, 10);
    pulse_lever_a();
    check("freeze_y1", 32'(bus_a.elev_y[1]), 197);
    check("freeze_ticks", 32'(ticks_a - t0), 0);
    check("freeze_lever_on", 32'(bus_a.elev_on), 0);
    check("freeze_moving", 32'(bus_a.elev_moving), 32'(2'b10));
    bus_a.freeze = 1'b0;
    edges(1'b0, 1);
    check("unfreeze_div_hold_y1", 32'(bus_a.elev_y[1]), 197);
    edges(1'b0, 1);
    check("unfreeze_step_y1", 32'(bus_a.elev_y[1]), 198);

    // STEP=5, FRAME_DIV=1: mid-travel reset snap, then clamped arrival.
    @(negedge Clk);
    bus_b.switch_pressed = 4'b0001;
    repeat (2) @(negedge Clk);
    edges(1'b1, 1);
    check("step5_first_y0", 32'(bus_b.elev_y[0]), 261);
    edges(1'b1, 4);
    check("step5_pre_reset_y0", 32'(bus_b.elev_y[0]), 281);
    rst_b = 1'b1;
    @(negedge Clk);
    check("step5_reset_snap_y0", 32'(bus_b.elev_y[0]), 256);
    check("step5_reset_moving", 32'(bus_b.elev_moving), 0);
    rst_b = 1'b0;
    repeat (2) @(negedge Clk);
    edges(1'b1, 9);
    check("step5_y0_301", 32'(bus_b.elev_y[0]), 301);
    check("step5_moving", 32'(bus_b.elev_moving), 32'(2'b01));
    edges(1'b1, 1);
    check("step5_clamp_y0", 32'(bus_b.elev_y[0]), 303);
    check("step5_at_end", 32'(bus_b.elev_at_end), 32'(2'b01));
    check("step5_y1_idle", 32'(bus_b.elev_y[1]), 208);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
